// File: rtl/parking_lot_meter.sv
// parking_lot_meter: three-space lot meter. Drives lot LEDs and gates, counts
// arrivals per space, logs the hourly lot total to an 8-word RAM and shows a
// day view or an end-of-day scrolling summary on six active-low 7-seg digits.
module parking_lot_meter #(
    parameter int SCROLL_LOG2 = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key0_n,
    input  logic [2:0] park_present,
    input  logic       entr_present,
    input  logic       exit_present,
    output logic [2:0] led_spot,
    output logic       led_full,
    output logic       gate_entr,
    output logic       gate_exit,
    output logic [4:0] ledr,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5
);

    localparam logic [4:0] SPOT_MAX  = 5'd25;
    localparam logic [3:0] HOUR_END  = 4'd8;
    localparam logic [3:0] NO_HOUR   = 4'hF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_U     = 7'h41;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [2:0]  park_prev;
    logic        press_prev;
    logic        press;
    logic [2:0]  spot_pulse;
    logic        press_pulse;
    logic [4:0]  spot1_cnt;
    logic [4:0]  spot2_cnt;
    logic [4:0]  spot3_cnt;
    logic [3:0]  hour;
    logic        hour_end;
    logic        entering_end;
    logic [6:0]  lot_total;
    logic [15:0] log_ram [8];
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [11:0] rd_data_unused;
    logic [SCROLL_LOG2-1:0] scroll_div;
    logic        scroll_tick;
    logic [2:0]  scroll;
    logic [3:0]  rush_start;
    logic [3:0]  rush_end;
    logic [1:0]  occupied;
    logic [6:0]  hex0_nxt, hex1_nxt, hex2_nxt, hex3_nxt, hex4_nxt, hex5_nxt;

    assign led_spot  = park_present;
    assign led_full  = &park_present;
    assign gate_entr = entr_present;
    assign gate_exit = exit_present;
    assign ledr      = {exit_present, entr_present, park_present};

    // Pulses are suppressed while reset is held so nothing counts or logs then.
    assign press       = ~key0_n;
    assign spot_pulse  = park_present & ~park_prev & {3{~rst}};
    assign press_pulse = press & ~press_prev & ~rst;

    assign hour_end     = (hour == HOUR_END);
    assign entering_end = press_pulse && (hour == HOUR_END - 4'd1);
    assign lot_total    = {2'b00, spot1_cnt} + {2'b00, spot2_cnt} + {2'b00, spot3_cnt};
    assign scroll_tick  = &scroll_div;

    // Only the low digit of a log word is displayed; the rest stays in the record.
    assign rd_data_unused = rd_data[15:4];

    // Previous-input registers track inputs every cycle, reset included, so release never pulses
    always_ff @(posedge clk) begin
        park_prev  <= park_present;
        press_prev <= press;
    end

    // Per-space arrival counters, saturating at SPOT_MAX
    always_ff @(posedge clk) begin
        if (rst) begin
            spot1_cnt <= '0;
            spot2_cnt <= '0;
            spot3_cnt <= '0;
        end else begin
            if (spot_pulse[0] && spot1_cnt != SPOT_MAX) spot1_cnt <= spot1_cnt + 5'd1;
            if (spot_pulse[1] && spot2_cnt != SPOT_MAX) spot2_cnt <= spot2_cnt + 5'd1;
            if (spot_pulse[2] && spot3_cnt != SPOT_MAX) spot3_cnt <= spot3_cnt + 5'd1;
        end
    end

    // Hour counter; hour 8 is end-of-day and absorbs further presses
    always_ff @(posedge clk) begin
        if (rst)
            hour <= '0;
        else if (press_pulse && !hour_end)
            hour <= hour + 4'd1;
    end

    // Log the pre-edge lot total at the old hour's address; contents survive reset
    always_ff @(posedge clk) begin
        if (press_pulse && !hour_end)
            log_ram[hour[2:0]] <= {9'd0, lot_total};
    end

    // Read address follows the hour during the day and the scroll position at end of day
    always_ff @(posedge clk) begin
        if (rst)
            rd_addr <= '0;
        else
            rd_addr <= hour_end ? scroll : hour[2:0];
    end

    // Registered RAM read
    always_ff @(posedge clk) begin
        rd_data <= log_ram[rd_addr];
    end

    // Free-running divider producing the scroll tick
    always_ff @(posedge clk) begin
        if (rst)
            scroll_div <= '0;
        else
            scroll_div <= scroll_div + SCROLL_LOG2'(1);
    end

    // Scroll position restarts at 0 on entry to end-of-day; the clear beats a coincident tick
    always_ff @(posedge clk) begin
        if (rst || entering_end)
            scroll <= '0;
        else if (scroll_tick)
            scroll <= scroll + 3'd1;
    end

    // First hour the lot was full, then first later hour it was empty; once per day
    always_ff @(posedge clk) begin
        if (rst) begin
            rush_start <= NO_HOUR;
            rush_end   <= NO_HOUR;
        end else if (!hour_end) begin
            if (&park_present && rush_start == NO_HOUR)
                rush_start <= hour;
            if (park_present == 3'b000 && rush_start != NO_HOUR && rush_end == NO_HOUR)
                rush_end <= hour;
        end
    end

    // Display content for the day view or the end-of-day summary
    always_comb begin
        occupied = {1'b0, park_present[0]} + {1'b0, park_present[1]} + {1'b0, park_present[2]};
        hex0_nxt = SEG_BLANK;
        hex1_nxt = SEG_BLANK;
        hex2_nxt = SEG_BLANK;
        hex3_nxt = SEG_BLANK;
        hex4_nxt = SEG_BLANK;
        hex5_nxt = SEG_BLANK;
        if (!hour_end) begin
            if (&park_present) begin
                hex3_nxt = SEG_F;
                hex2_nxt = SEG_U;
                hex1_nxt = SEG_L;
                hex0_nxt = SEG_L;
            end else begin
                hex0_nxt = SEG_TABLE[4'd3 - {2'b00, occupied}];
            end
            hex5_nxt = SEG_TABLE[hour];
        end else begin
            hex1_nxt = SEG_TABLE[rd_data[3:0]];
            hex2_nxt = SEG_TABLE[{1'b0, rd_addr}];
            hex3_nxt = (rush_start == NO_HOUR) ? SEG_DASH : SEG_TABLE[rush_start];
            hex4_nxt = (rush_end == NO_HOUR) ? SEG_DASH : SEG_TABLE[rush_end];
        end
    end

    // Registered display outputs, blank in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            hex0 <= SEG_BLANK;
            hex1 <= SEG_BLANK;
            hex2 <= SEG_BLANK;
            hex3 <= SEG_BLANK;
            hex4 <= SEG_BLANK;
            hex5 <= SEG_BLANK;
        end else begin
            hex0 <= hex0_nxt;
            hex1 <= hex1_nxt;
            hex2 <= hex2_nxt;
            hex3 <= hex3_nxt;
            hex4 <= hex4_nxt;
            hex5 <= hex5_nxt;
        end
    end

endmodule

// File: tb/tb_parking_lot_meter.sv
// Scoreboard bench for parking_lot_meter: stimulus queues expected values tagged
// with the cycle they must hold in; a monitor compares them on the falling edge.
module tb_parking_lot_meter;

    logic       clk = 1'b0;
    logic       rst;
    logic       key0_n;
    logic [2:0] park_present;
    logic       entr_present;
    logic       exit_present;
    logic [2:0] led_spot;
    logic       led_full;
    logic       gate_entr;
    logic       gate_exit;
    logic [4:0] ledr;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

    always #5 clk = ~clk;

    parking_lot_meter #(.SCROLL_LOG2(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .key0_n       (key0_n),
        .park_present (park_present),
        .entr_present (entr_present),
        .exit_present (exit_present),
        .led_spot     (led_spot),
        .led_full     (led_full),
        .gate_entr    (gate_entr),
        .gate_exit    (gate_exit),
        .ledr         (ledr),
        .hex0         (hex0),
        .hex1         (hex1),
        .hex2         (hex2),
        .hex3         (hex3),
        .hex4         (hex4),
        .hex5         (hex5)
    );

    localparam int S_HEX0 = 0, S_HEX1 = 1, S_HEX2 = 2, S_HEX3 = 3, S_HEX4 = 4, S_HEX5 = 5;
    localparam int S_SPOT = 6, S_FULL = 7, S_LEDR = 8, S_GENT = 9, S_GEXT = 10;
    localparam int S_CNT1 = 11, S_CNT2 = 12, S_CNT3 = 13, S_HOUR = 14, S_RS = 15, S_RE = 16;

    typedef struct {
        int    due;
        int    sig;
        int    exp;
        string name;
    } chk_t;

    chk_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   r_edge   = 0;
    int   e_edge   = 0;
    int   last_press_edge = 0;
    int   seg_tab [16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                           'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};
    int   exp_log_seg [8];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int observe(input int sig);
        case (sig)
            S_HEX0: return int'(hex0);
            S_HEX1: return int'(hex1);
            S_HEX2: return int'(hex2);
            S_HEX3: return int'(hex3);
            S_HEX4: return int'(hex4);
            S_HEX5: return int'(hex5);
            S_SPOT: return int'(led_spot);
            S_FULL: return int'(led_full);
            S_LEDR: return int'(ledr);
            S_GENT: return int'(gate_entr);
            S_GEXT: return int'(gate_exit);
            S_CNT1: return int'(dut.spot1_cnt);
            S_CNT2: return int'(dut.spot2_cnt);
            S_CNT3: return int'(dut.spot3_cnt);
            S_HOUR: return int'(dut.hour);
            S_RS:   return int'(dut.rush_start);
            S_RE:   return int'(dut.rush_end);
            default: return -1;
        endcase
    endfunction

    // Queue an expectation that must hold at the falling edge 'delay' cycles from now.
    task automatic expect_val(input int sig, input int exp, input string name, input int delay);
        chk_t c;
        int   i;
        c.due  = cyc + delay;
        c.sig  = sig;
        c.exp  = exp;
        c.name = name;
        i = sb_q.size();
        while (i > 0 && sb_q[i-1].due > c.due) i--;
        sb_q.insert(i, c);
    endtask

    // Monitor: pops and compares every expectation that has come due.
    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                chk_t c;
                int   act;
                c   = sb_q.pop_front();
                act = observe(c.sig);
                n_checks++;
                if (c.due < cyc) begin
                    n_fail++;
                    $display("FAIL %s: check slipped past its cycle (due %0d, now %0d)", c.name, c.due, cyc);
                end else if (act != c.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", c.name, act, c.exp, cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        expect_val(S_HEX0, 'h7F, "hex0_in_reset", 0);
        expect_val(S_HEX5, 'h7F, "hex5_in_reset", 0);
        rst    = 1'b0;
        r_edge = cyc;
    endtask

    task automatic press_key();
        key0_n = 1'b0;
        last_press_edge = cyc + 1;
        tick(3);
        key0_n = 1'b1;
        tick(3);
    endtask

    function automatic int scroll_at(input int t);
        return (((t - r_edge) / 16) - ((e_edge - r_edge) / 16)) % 8;
    endfunction

    // End-of-day view: hex2 shows the read address, hex1 the logged digit at that address.
    task automatic scroll_check(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            expect_val(S_HEX2, seg_tab[scroll_at(cyc - 2)], "scroll_addr_hex2", 0);
            expect_val(S_HEX1, exp_log_seg[scroll_at(cyc - 3)], "scroll_log_hex1", 0);
            tick(1);
        end
    endtask

    initial begin
        rst          = 1'b1;
        key0_n       = 1'b1;
        park_present = 3'b000;
        entr_present = 1'b0;
        exit_present = 1'b0;
        tick(1);

        // Reset state with idle inputs
        do_reset();
        tick(2);
        expect_val(S_HEX0, 'h30, "reset_hex0_3free", 0);
        expect_val(S_HEX1, 'h7F, "reset_hex1", 0);
        expect_val(S_HEX2, 'h7F, "reset_hex2", 0);
        expect_val(S_HEX3, 'h7F, "reset_hex3", 0);
        expect_val(S_HEX4, 'h7F, "reset_hex4", 0);
        expect_val(S_HEX5, 'h40, "reset_hex5_hour0", 0);
        expect_val(S_CNT1, 0, "reset_cnt1", 0);
        expect_val(S_CNT2, 0, "reset_cnt2", 0);
        expect_val(S_CNT3, 0, "reset_cnt3", 0);
        expect_val(S_HOUR, 0, "reset_hour", 0);
        expect_val(S_RS, 'hF, "reset_rush_start", 0);
        expect_val(S_RE, 'hF, "reset_rush_end", 0);
        expect_val(S_FULL, 0, "reset_led_full", 0);

        // Space 1: held, released, re-occupied
        park_present = 3'b001;
        expect_val(S_SPOT, 1, "led_spot_comb", 0);
        expect_val(S_CNT1, 0, "cnt1_before_edge", 0);
        expect_val(S_HEX0, 'h30, "hex0_registered_lag", 0);
        expect_val(S_CNT1, 1, "cnt1_first_arrival", 1);
        expect_val(S_HEX0, 'h24, "hex0_2free", 1);
        tick(10);
        expect_val(S_CNT1, 1, "cnt1_held_no_recount", 0);
        park_present = 3'b000;
        tick(2);
        expect_val(S_HEX0, 'h30, "hex0_3free_again", 0);
        park_present = 3'b001;
        tick(2);
        expect_val(S_CNT1, 2, "cnt1_second_arrival", 0);
        expect_val(S_SPOT, 1, "led_spot_001", 0);
        expect_val(S_HEX0, 'h24, "hex0_2free_again", 0);

        // Gate pass-through and ledr packing
        entr_present = 1'b1;
        expect_val(S_GENT, 1, "gate_entr", 0);
        expect_val(S_GEXT, 0, "gate_exit_idle", 0);
        expect_val(S_LEDR, 'h09, "ledr_entr", 0);
        tick(1);
        exit_present = 1'b1;
        expect_val(S_GEXT, 1, "gate_exit", 0);
        expect_val(S_LEDR, 'h19, "ledr_entr_exit", 0);
        tick(1);
        entr_present = 1'b0;
        exit_present = 1'b0;
        tick(1);

        // Full lot and space-3 saturation
        park_present = 3'b111;
        expect_val(S_FULL, 1, "led_full", 0);
        expect_val(S_CNT2, 1, "cnt2_arrival", 1);
        expect_val(S_CNT3, 1, "cnt3_arrival", 1);
        expect_val(S_HEX3, 'h0E, "full_hex3_F", 1);
        expect_val(S_HEX2, 'h41, "full_hex2_U", 1);
        expect_val(S_HEX1, 'h47, "full_hex1_L", 1);
        expect_val(S_HEX0, 'h47, "full_hex0_L", 1);
        expect_val(S_HEX4, 'h7F, "full_hex4_blank", 1);
        expect_val(S_RS, 0, "rush_start_hour0", 1);
        tick(2);
        for (int i = 0; i < 23; i++) begin
            park_present = 3'b011;
            tick(1);
            park_present = 3'b111;
            tick(1);
        end
        expect_val(S_CNT3, 24, "cnt3_at_24", 0);
        park_present = 3'b011;
        tick(1);
        park_present = 3'b111;
        tick(1);
        expect_val(S_CNT3, 25, "cnt3_reaches_25", 0);
        for (int i = 0; i < 2; i++) begin
            park_present = 3'b011;
            tick(1);
            park_present = 3'b111;
            tick(1);
        end
        expect_val(S_CNT3, 25, "cnt3_saturated", 0);
        expect_val(S_RE, 'hF, "rush_end_not_empty", 0);

        // New day: press and space 1 held across reset release
        park_present = 3'b001;
        key0_n       = 1'b0;
        do_reset();
        tick(3);
        expect_val(S_HOUR, 0, "held_press_no_hour", 0);
        expect_val(S_CNT1, 0, "held_space_no_count", 0);
        expect_val(S_CNT3, 0, "midop_reset_cnt3", 0);
        expect_val(S_RS, 'hF, "midop_reset_rush", 0);
        expect_val(S_HEX0, 'h24, "day2_hex0", 0);
        key0_n = 1'b1;
        tick(2);
        park_present = 3'b000;
        tick(2);

        press_key();
        expect_val(S_HOUR, 1, "hour1", 0);
        expect_val(S_HEX5, 'h79, "hex5_hour1", 0);
        press_key();
        expect_val(S_HOUR, 2, "hour2", 0);
        expect_val(S_HEX5, 'h24, "hex5_hour2", 0);

        park_present = 3'b001;
        tick(2);
        park_present = 3'b011;
        tick(2);
        expect_val(S_HEX0, 'h79, "hex0_1free", 0);
        park_present = 3'b001;
        tick(2);
        park_present = 3'b011;
        tick(2);
        expect_val(S_CNT1, 1, "h2_cnt1", 0);
        expect_val(S_CNT2, 2, "h2_cnt2", 0);
        expect_val(S_CNT3, 0, "h2_cnt3", 0);
        press_key();
        expect_val(S_HOUR, 3, "hour3", 0);

        // Press and space-1 arrival on the same edge
        park_present = 3'b010;
        tick(2);
        park_present = 3'b011;
        key0_n       = 1'b0;
        tick(1);
        expect_val(S_HOUR, 4, "same_edge_hour4", 0);
        expect_val(S_CNT1, 2, "same_edge_cnt1", 0);
        tick(2);
        key0_n = 1'b1;
        tick(3);
        press_key();
        expect_val(S_HOUR, 5, "hour5", 0);

        park_present = 3'b111;
        tick(2);
        expect_val(S_RS, 5, "rush_start_hour5", 0);
        expect_val(S_HEX3, 'h0E, "h5_full_hex3", 0);
        expect_val(S_HEX5, 'h12, "hex5_hour5", 0);
        press_key();
        press_key();
        expect_val(S_HOUR, 7, "hour7", 0);
        expect_val(S_RS, 5, "rush_start_kept", 0);
        park_present = 3'b000;
        tick(2);
        expect_val(S_RE, 7, "rush_end_hour7", 0);
        expect_val(S_HEX0, 'h30, "h7_hex0_3free", 0);
        press_key();
        e_edge = last_press_edge;
        expect_val(S_HOUR, 8, "hour8", 0);
        expect_val(S_HEX3, 'h12, "end_hex3_rush5", 0);
        expect_val(S_HEX4, 'h78, "end_hex4_rush7", 0);
        expect_val(S_HEX5, 'h7F, "end_hex5_blank", 0);
        expect_val(S_HEX0, 'h7F, "end_hex0_blank", 0);
        press_key();
        expect_val(S_HOUR, 8, "ninth_press_hour8", 0);

        exp_log_seg = '{'h40, 'h40, 'h30, 'h30, 'h19, 'h12, 'h12, 'h12};
        scroll_check(140);

        // Never-full day, then a press at hour 8 that must not write the log
        park_present = 3'b000;
        do_reset();
        tick(2);
        expect_val(S_HOUR, 0, "day3_hour0", 0);
        expect_val(S_HEX5, 'h40, "day3_hex5", 0);
        expect_val(S_HEX3, 'h7F, "day3_hex3", 0);
        for (int i = 0; i < 8; i++) press_key();
        e_edge = cyc - 5;
        expect_val(S_HOUR, 8, "day3_hour8", 0);
        expect_val(S_HEX3, 'h3F, "never_full_hex3_dash", 0);
        expect_val(S_HEX4, 'h3F, "never_full_hex4_dash", 0);
        park_present = 3'b001;
        tick(2);
        expect_val(S_CNT1, 1, "day3_cnt1", 0);
        press_key();
        expect_val(S_HOUR, 8, "day3_hour_sat", 0);
        exp_log_seg = '{'h40, 'h40, 'h40, 'h40, 'h40, 'h40, 'h40, 'h40};
        scroll_check(140);

        for (int i = 0; i < 20; i++) if (sb_q.size() > 0) tick(1);
        while (sb_q.size() > 0) begin
            chk_t c;
            c = sb_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never compared (due %0d, now %0d)", c.name, c.due, cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
